// File: rtl/md5_core_arbiter_if.sv
// Bundle between the guess requesters, the shared MD5 core and the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface md5_core_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 5
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [127:0]             target_hash;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*128-1:0]   req_word;
  logic [NUM_REQ*LEN_W-1:0] req_width;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     core_ready;
  logic                     core_start;
  logic [127:0]             core_word;
  logic [LEN_W-1:0]         core_width;
  logic                     core_valid;
  logic [127:0]             core_hash;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [127:0]             rsp_hash;
  logic                     match;
  logic [ID_W-1:0]          match_id;
  logic [127:0]             match_word;
  logic                     timeout_err;
  logic [31:0]              hash_count;
  logic                     busy;

  modport slave (
    input  target_hash, req_valid, req_word, req_width, core_ready, core_valid, core_hash,
    output req_ready, core_start, core_word, core_width, rsp_valid, rsp_id, rsp_hash,
           match, match_id, match_word, timeout_err, hash_count, busy
  );

  modport master (
    output target_hash, req_valid, req_word, req_width, core_ready, core_valid, core_hash,
    input  req_ready, core_start, core_word, core_width, rsp_valid, rsp_id, rsp_hash,
           match, match_id, match_word, timeout_err, hash_count, busy
  );
endinterface

// File: rtl/md5_core_arbiter.sv
// Round-robin arbiter feeding password guesses from NUM_REQ requesters into one
// MD5 core, returning each digest and latching the first guess that hits the target.
module md5_core_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  md5_core_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_FOUND} state_t;

  state_t             r_state, w_next;
  logic [ID_W-1:0]    r_last_grant, r_id, r_match_id;
  logic [ID_W-1:0]    w_grant_id, w_cand;
  logic               w_grant_vld;
  logic [127:0]       r_word, r_hash, r_match_word, w_sel_word;
  logic [LEN_W-1:0]   r_width, w_sel_width;
  logic [15:0]        r_wait_cnt;
  logic               r_match, r_timeout_err;
  logic [31:0]        r_hash_count;
  logic               w_timeout;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_core_start, w_rsp_valid, w_busy;

  assign w_timeout = (r_wait_cnt == 16'(TIMEOUT));

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_grant_vld && (w_cand == ID_W'(i)) && bus.req_valid[i]) begin
          w_grant_vld = 1'b1;
          w_grant_id  = w_cand;
        end
      end
    end
  end

  always_comb begin
    w_sel_word  = '0;
    w_sel_width = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        w_sel_word  = bus.req_word[128*i +: 128];
        w_sel_width = bus.req_width[LEN_W*i +: LEN_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_vld) w_next = S_ISSUE;
      S_ISSUE: if (bus.core_ready) w_next = S_WAIT;
      S_WAIT:  if (bus.core_valid) w_next = S_RESP;
               else if (w_timeout) w_next = S_IDLE;
      S_RESP:  w_next = (r_hash == bus.target_hash) ? S_FOUND : S_IDLE;
      S_FOUND: w_next = S_FOUND;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_req_ready  = '0;
    w_core_start = 1'b0;
    w_rsp_valid  = 1'b0;
    w_busy       = (r_state != S_IDLE) && (r_state != S_FOUND);
    case (r_state)
      S_IDLE:  if (w_grant_vld) w_req_ready = NUM_REQ'(1) << w_grant_id;
      S_ISSUE: w_core_start = bus.core_ready;
      S_RESP:  w_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Guess and result registers; everything is cleared so outputs read zero in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant  <= ID_W'(NUM_REQ - 1);
      r_id          <= '0;
      r_word        <= '0;
      r_width       <= '0;
      r_hash        <= '0;
      r_wait_cnt    <= '0;
      r_match       <= 1'b0;
      r_match_id    <= '0;
      r_match_word  <= '0;
      r_timeout_err <= 1'b0;
      r_hash_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_grant_vld) begin
          r_last_grant <= w_grant_id;
          r_id         <= w_grant_id;
          r_word       <= w_sel_word;
          r_width      <= w_sel_width;
        end
        S_ISSUE: if (bus.core_ready) r_wait_cnt <= '0;
        S_WAIT: begin
          if (bus.core_valid)  r_hash <= bus.core_hash;
          else if (w_timeout)  r_timeout_err <= 1'b1;
          else                 r_wait_cnt <= r_wait_cnt + 16'd1;
        end
        S_RESP: begin
          r_hash_count <= r_hash_count + 32'd1;
          if (r_hash == bus.target_hash) begin
            r_match      <= 1'b1;
            r_match_id   <= r_id;
            r_match_word <= r_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.core_start  = w_core_start;
  assign bus.core_word   = r_word;
  assign bus.core_width  = r_width;
  assign bus.rsp_valid   = w_rsp_valid;
  assign bus.rsp_id      = r_id;
  assign bus.rsp_hash    = r_hash;
  assign bus.match       = r_match;
  assign bus.match_id    = r_match_id;
  assign bus.match_word  = r_match_word;
  assign bus.timeout_err = r_timeout_err;
  assign bus.hash_count  = r_hash_count;
  assign bus.busy        = w_busy;
endmodule

// File: tb/tb_md5_core_arbiter.sv
// Directed bench for md5_core_arbiter: the core side is driven by hand, cycle by cycle.
module tb_md5_core_arbiter;
  localparam int NUM_REQ = 4;
  localparam int LEN_W   = 5;
  localparam logic [127:0] T    = 128'h5014bf4efb93a883b348004c9b90ddc6;
  localparam logic [127:0] H    = 128'h0123456789abcdef0011223344556677;
  localparam logic [127:0] AKHA = 128'h616b6861;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   e;
  int   n;
  bit   saw;

  md5_core_arbiter_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) bus ();

  md5_core_arbiter #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.target_hash = T;
    bus.req_valid   = '0;
    bus.req_word    = '0;
    bus.req_width   = '0;
    bus.core_ready  = 1'b1;
    bus.core_valid  = 1'b0;
    bus.core_hash   = '0;
    repeat (3) step();

    // reset state
    check("rst_req_ready",  128'(bus.req_ready),  128'(0));
    check("rst_core_start", 128'(bus.core_start), 128'(0));
    check("rst_core_word",  bus.core_word,        128'(0));
    check("rst_core_width", 128'(bus.core_width), 128'(0));
    check("rst_rsp_valid",  128'(bus.rsp_valid),  128'(0));
    check("rst_match",      128'(bus.match),      128'(0));
    check("rst_timeout",    128'(bus.timeout_err),128'(0));
    check("rst_hash_count", 128'(bus.hash_count), 128'(0));
    check("rst_busy",       128'(bus.busy),       128'(0));
    reset = 1'b1;
    step();

    // single requester 0 hits the target
    bus.req_word[127:0] = AKHA;
    bus.req_width[4:0]  = 5'd4;
    bus.req_valid       = 4'b0001;
    #1;
    check("t1_req_ready", 128'(bus.req_ready), 128'(4'b0001));
    check("t1_idle_busy", 128'(bus.busy), 128'(0));
    step();
    bus.req_valid = '0;
    check("t1_core_start", 128'(bus.core_start), 128'(1));
    check("t1_core_word",  bus.core_word, AKHA);
    check("t1_core_width", 128'(bus.core_width), 128'(4));
    check("t1_issue_ready",128'(bus.req_ready), 128'(0));
    check("t1_issue_busy", 128'(bus.busy), 128'(1));
    step();
    bus.core_valid = 1'b1;
    bus.core_hash  = T;
    check("t1_wait_start", 128'(bus.core_start), 128'(0));
    step();
    bus.core_valid = 1'b0;
    check("t1_rsp_valid", 128'(bus.rsp_valid), 128'(1));
    check("t1_rsp_id",    128'(bus.rsp_id), 128'(0));
    check("t1_rsp_hash",  bus.rsp_hash, T);
    step();
    check("t1_match",      128'(bus.match), 128'(1));
    check("t1_match_id",   128'(bus.match_id), 128'(0));
    check("t1_match_word", bus.match_word, AKHA);
    check("t1_found_busy", 128'(bus.busy), 128'(0));
    check("t1_hash_count", 128'(bus.hash_count), 128'(1));
    check("t1_rsp_drop",   128'(bus.rsp_valid), 128'(0));
    reset = 1'b0;
    #1;
    check("t1_rst_match", 128'(bus.match), 128'(0));
    check("t1_rst_count", 128'(bus.hash_count), 128'(0));
    step();
    reset = 1'b1;
    step();

    // all four requesters held valid, no hits: grant order 0,1,2,3,0
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_word[128*i +: 128]    = 128'hA000 + 128'(i);
      bus.req_width[LEN_W*i +: LEN_W] = LEN_W'(i + 1);
    end
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      #1;
      check("t2_req_ready", 128'(bus.req_ready), 128'(4'b0001 << e));
      step();
      check("t2_core_start", 128'(bus.core_start), 128'(1));
      check("t2_core_word",  bus.core_word, 128'hA000 + 128'(e));
      step();
      bus.core_valid = 1'b1;
      bus.core_hash  = H;
      step();
      bus.core_valid = 1'b0;
      check("t2_rsp_valid", 128'(bus.rsp_valid), 128'(1));
      check("t2_rsp_id",    128'(bus.rsp_id), 128'(e));
      if (k == 4) bus.req_valid = '0;
      step();
    end
    check("t2_hash_count", 128'(bus.hash_count), 128'(5));
    check("t2_idle_ready", 128'(bus.req_ready), 128'(0));
    check("t2_idle_busy",  128'(bus.busy), 128'(0));
    check("t2_no_match",   128'(bus.match), 128'(0));

    // core stalls for 10 cycles after the grant
    bus.core_ready = 1'b0;
    bus.req_valid  = 4'b0100;
    #1;
    check("t3_req_ready", 128'(bus.req_ready), 128'(4'b0100));
    step();
    bus.req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      check("t3_stall_start", 128'(bus.core_start), 128'(0));
      check("t3_stall_busy",  128'(bus.busy), 128'(1));
      step();
    end
    bus.core_ready = 1'b1;
    #1;
    check("t3_core_start", 128'(bus.core_start), 128'(1));
    check("t3_core_word",  bus.core_word, 128'hA002);
    check("t3_core_width", 128'(bus.core_width), 128'(3));
    step();
    check("t3_single_pulse", 128'(bus.core_start), 128'(0));
    bus.core_valid = 1'b1;
    bus.core_hash  = H;
    step();
    bus.core_valid = 1'b0;
    check("t3_rsp_valid", 128'(bus.rsp_valid), 128'(1));
    check("t3_rsp_id",    128'(bus.rsp_id), 128'(2));
    step();
    check("t3_hash_count", 128'(bus.hash_count), 128'(6));

    // core never answers: timeout after the wait counter reaches 255
    bus.req_valid = 4'b1000;
    #1;
    check("t4_req_ready", 128'(bus.req_ready), 128'(4'b1000));
    step();
    bus.req_valid = '0;
    check("t4_core_start", 128'(bus.core_start), 128'(1));
    n   = 0;
    saw = 1'b0;
    while (!bus.timeout_err && n < 400) begin
      step();
      n++;
      if (bus.rsp_valid) saw = 1'b1;
    end
    check("t4_timeout_cycles", 128'(n), 128'(257));
    check("t4_no_rsp",         128'(saw), 128'(0));
    check("t4_timeout_err",    128'(bus.timeout_err), 128'(1));
    check("t4_idle_busy",      128'(bus.busy), 128'(0));
    check("t4_hash_count",     128'(bus.hash_count), 128'(6));
    bus.req_valid = 4'hF;
    #1;
    check("t4_next_grant", 128'(bus.req_ready), 128'(4'b0001));

    // reset while waiting on the core, then a stale result arrives
    step();
    bus.req_valid = '0;
    check("t5_core_start", 128'(bus.core_start), 128'(1));
    step();
    check("t5_wait_busy", 128'(bus.busy), 128'(1));
    reset = 1'b0;
    #1;
    check("t5_busy",       128'(bus.busy), 128'(0));
    check("t5_timeout",    128'(bus.timeout_err), 128'(0));
    check("t5_core_word",  bus.core_word, 128'(0));
    check("t5_core_width", 128'(bus.core_width), 128'(0));
    check("t5_core_start", 128'(bus.core_start), 128'(0));
    check("t5_req_ready",  128'(bus.req_ready), 128'(0));
    check("t5_rsp_valid",  128'(bus.rsp_valid), 128'(0));
    check("t5_rsp_hash",   bus.rsp_hash, 128'(0));
    step();
    reset          = 1'b1;
    bus.core_valid = 1'b1;
    bus.core_hash  = T;
    #1;
    check("t5_late_rsp0", 128'(bus.rsp_valid), 128'(0));
    step();
    bus.core_valid = 1'b0;
    check("t5_late_rsp1", 128'(bus.rsp_valid), 128'(0));
    check("t5_late_busy", 128'(bus.busy), 128'(0));
    check("t5_late_match",128'(bus.match), 128'(0));
    check("t5_late_count",128'(bus.hash_count), 128'(0));

    // requester 2 hits while everyone keeps requesting
    bus.req_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t6_req_ready", 128'(bus.req_ready), 128'(4'b0001 << k));
      step();
      check("t6_core_start", 128'(bus.core_start), 128'(1));
      step();
      bus.core_valid = 1'b1;
      bus.core_hash  = (k == 2) ? T : H;
      step();
      bus.core_valid = 1'b0;
      check("t6_rsp_id", 128'(bus.rsp_id), 128'(k));
      step();
    end
    check("t6_match",      128'(bus.match), 128'(1));
    check("t6_match_id",   128'(bus.match_id), 128'(2));
    check("t6_match_word", bus.match_word, 128'hA002);
    for (int k = 0; k < 12; k++) begin
      bus.core_valid = (k == 3);
      bus.core_hash  = H;
      #1;
      check("t6_found_ready", 128'(bus.req_ready), 128'(0));
      check("t6_found_start", 128'(bus.core_start), 128'(0));
      check("t6_found_rsp",   128'(bus.rsp_valid), 128'(0));
      step();
    end
    bus.core_valid = 1'b0;
    check("t6_hold_match", 128'(bus.match), 128'(1));
    check("t6_hold_id",    128'(bus.match_id), 128'(2));
    check("t6_hold_count", 128'(bus.hash_count), 128'(3));
    check("t6_hold_busy",  128'(bus.busy), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/md5_core_arbiter.md
MD5_CORE_ARBITER -- requirements
Module: md5_core_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of guess requesters sharing one MD5 core (2..8).
REQ-002 Parameter LEN_W, default 5: width of a guess-length field, in bytes, 0..16.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles to wait for a core result.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 target_hash  in  128  hash to match; held stable while reset is high.
REQ-007 req_valid  in  NUM_REQ  per-requester guess valid; each requester holds it until its req_ready.
REQ-008 req_word  in  NUM_REQ*128  flattened guesses; requester i occupies bits [128*i+127:128*i].
REQ-009 req_width  in  NUM_REQ*LEN_W  flattened guess lengths, packed the same way.
REQ-010 req_ready  out  NUM_REQ  one-hot accept pulse.
REQ-011 core_ready  in  1  MD5 core idle and able to accept a start.
REQ-012 core_start  out  1  one-cycle start pulse to the core.
REQ-013 core_word / core_width  out  128 / LEN_W  guess presented to the core.
REQ-014 core_valid / core_hash  in  1 / 128  core result strobe and digest.
REQ-015 rsp_valid / rsp_id / rsp_hash  out  1 / clog2(NUM_REQ) / 128  per-guess result returned to the requesters.
REQ-016 match / match_id / match_word  out  1 / clog2(NUM_REQ) / 128  sticky found flag, winning requester and plaintext.
REQ-017 timeout_err  out  1  sticky flag set when the core fails to answer.
REQ-018 hash_count  out  32  number of completed hashes.
REQ-019 busy  out  1  high in every state except IDLE and FOUND.

Function
REQ-020 The FSM SHALL have the states IDLE, ISSUE, WAIT, RESP and FOUND.
REQ-021 IDLE: if any req_valid is high, grant round-robin starting at last_grant+1 (mod NUM_REQ), assert req_ready[grant] for exactly that cycle, latch word, width and id, then go to ISSUE.
REQ-022 At most one req_ready bit SHALL be high in any cycle; req_ready SHALL be 0 outside IDLE.
REQ-023 ISSUE: core_start SHALL be 1 for exactly one cycle, in the first cycle core_ready=1, then go to WAIT; while core_ready=0 the FSM holds ISSUE.
REQ-024 core_word and core_width SHALL stay stable from ISSUE entry until WAIT exits.
REQ-025 Latency: with core_ready=1, core_start SHALL occur in the cycle after req_ready.
REQ-026 WAIT: on core_valid=1, latch core_hash and go to RESP.
REQ-027 WAIT: a 16-bit wait counter, cleared on WAIT entry, increments each WAIT cycle without core_valid.
REQ-028 WAIT: when the wait counter reaches TIMEOUT, set timeout_err, drop the guess with no rsp_valid, and return to IDLE.
REQ-029 core_valid outside WAIT SHALL be ignored.
REQ-030 RESP: rsp_valid=1 for one cycle with rsp_id and rsp_hash; hash_count increments by 1 and wraps at 2^32.
REQ-031 RESP: if the latched hash equals target_hash, set match, match_id and match_word, then go to FOUND; otherwise go to IDLE.
REQ-032 FOUND is terminal until reset; no grants or core_start are issued in FOUND.
REQ-033 last_grant SHALL update only on a grant; a requester deasserting req_valid before its grant is legal and loses nothing.
REQ-034 A single active requester SHALL be granted back-to-back, once per pass through IDLE.

Reset
REQ-035 reset=0 SHALL force IDLE immediately, at any state including mid-WAIT.
REQ-036 Reset values: all outputs 0, except core_word=0 and core_width=0; last_grant=NUM_REQ-1, so requester 0 wins first.
REQ-037 A core result arriving after reset releases SHALL be ignored, since the FSM is then in IDLE.

Verification
REQ-038 Single requester 0, word "akha", width 4, core returns 5014bf4efb93a883b348004c9b90ddc6 equal to target -> rsp_valid, match=1, match_id=0, match_word="akha", FOUND, busy=0.
REQ-039 All 4 req_valid held high, non-matching hashes -> grant order 0,1,2,3,0, hash_count=5, req_ready one-hot.
REQ-040 core_ready held 0 for 10 cycles after a grant -> core_start stays 0, then pulses once in the first cycle core_ready=1.
REQ-041 No core_valid for TIMEOUT cycles -> timeout_err=1, no rsp_valid, return to IDLE, next requester is granted.
REQ-042 reset asserted in WAIT, then core_valid after release -> all outputs 0 and the late result is ignored (no rsp_valid).
REQ-043 Match on requester 2 while others keep req_valid high -> no further req_ready or core_start, and match holds until reset.
